uart_rx_multi: RTL and testbench
================================

Name: uart_rx_multi

Overview:
Parametrised next-generation UART receiver for the watchdog/debug serial path. It adds configurable oversampling, 5..8 data bits, 1 or 2 stop bits and parity with per-frame error flags. Received frames are buffered in an internal first-word-fall-through (FWFT) FIFO, so the consumer drains characters with a valid/ready handshake instead of a one-cycle strobe.

Parameters:
OSR, 8, samples per bit; legal 4..16; baud_en pulses at OSR x baudrate.
FIFO_DEPTH, 16, receive FIFO entries; power of 2, 2..256.
TIMEOUT_CHARS, 4, idle character times before rx_timeout asserts (optional feature only).

Ports:
clk_uart  in  1  UART reference clock, sole clock.
rst  in  1  synchronous reset, active-high.
baud_en  in  1  oversample tick, 1 clk_uart wide.
cfg_data_width  in  4  data bits 5..8; any other value is treated as 8.
cfg_parity_en  in  1  1 = a parity bit follows the data.
cfg_parity_odd  in  1  1 = odd parity, 0 = even.
cfg_stop2  in  1  1 = two stop bits.
cfg_err_drop  in  1  1 = do not store frames with parity or framing error.
rx_in  in  1  asynchronous serial line, idle high.
rx_data  out  8  FIFO head data, right-justified, zero-extended.
rx_perr  out  1  FIFO head parity error.
rx_ferr  out  1  FIFO head framing error.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer accept; pop when rx_valid && rx_ready.
rx_overflow  out  1  sticky: a frame was lost because the FIFO was full.
ovf_clr  in  1  clears rx_overflow.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count.
rx_timeout  out  1  idle timeout with FIFO not empty.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk_uart and rst.
- Reset values: all outputs 0. The synchroniser flops reset to 1. FSM goes to IDLE, FIFO empties. A reset mid-frame discards the partial frame.
- rx_in passes through a 3-flop synchroniser. s1 is the middle flop, s2 the last.
- IDLE: falling edge (s2=1, s1=0) -> START. Sample counter clears to 0. cfg_* values are latched at this point and held for the whole frame.
- Sample counter advances 0..OSR-1 on each baud_en, then wraps. MID = OSR/2.
- Bit value is a majority vote of s1 at counts MID-1, MID and MID+1. The vote resolves on the baud_en at MID+1; call this the decision tick.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- START: decision tick, vote 0 -> DATA; vote 1 -> IDLE (false start, nothing stored).
- DATA: bits are shifted in LSB-first. On the decision tick of bit cfg_data_width-1, go to PARITY if cfg_parity_en, otherwise STOP1.
- PARITY: the received bit is compared with the XOR of the data bits, XORed with cfg_parity_odd. A mismatch sets perr.
- STOP1: a vote of 0 sets ferr. Next state is STOP2 if cfg_stop2, otherwise IDLE.
- STOP2: a vote of 0 sets ferr. Next state is IDLE.
- Return to IDLE happens at the decision tick of the last stop bit, allowing resync on back-to-back frames.
- Push: the cycle after the last stop decision tick, {perr, ferr, data} is written to the FIFO. If cfg_err_drop is set and perr|ferr, nothing is written.
- Full FIFO: a push is discarded and rx_overflow sets. A pop in the same cycle is honoured first, so the push succeeds.
- rx_overflow: a set on the same cycle as ovf_clr wins.
- FWFT timing: rx_valid and head data are visible the clock after a push into an empty FIFO. A pop presents the next entry the following clock.
- Width handling: for widths below 8, unused upper bits of rx_data are 0.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined: a counter counts baud_en ticks while the FSM is in IDLE and the FIFO is non-empty. At TIMEOUT_CHARS*10*OSR ticks, rx_timeout asserts. It holds until the FIFO empties or a start edge is detected; either event also clears the counter.
- Undefined: rx_timeout is tied to 0 and no counter logic exists.

Decomposition:
- Package uart_rx_pkg holds: FSM state typedef (6 states), FIFO word width constant (10 = 8 data + perr + ferr), parity mode constants, default OSR.
- Sub-module uart_rx_fifo: synchronous FWFT FIFO with parameters DEPTH and WIDTH, providing push, pop, full, empty and level.

Test Plan:
- OSR=8, 8N1, send 0xA5 -> one entry: rx_data=0xA5, perr=0, ferr=0; fifo_level goes 0->1; rx_valid rises 1 clk after push.
- 7E1 with 0x35, parity bit corrupted to 1 -> entry data 0x35, perr=1. Repeat with cfg_err_drop=1 -> no entry, fifo_level stays 0.
- 8N2, second stop bit driven 0 -> ferr=1, data intact. A 3-sample low glitch (fewer than 2 votes of 0) on rx_in -> returns to IDLE, no entry.
- FIFO_DEPTH=4, rx_ready=0, send 5 frames -> level=4, rx_overflow=1, the fifth frame is lost. ovf_clr -> rx_overflow=0. Pop coincident with a push at full -> level stays 4, no overflow.
- Assert rst mid-DATA, then send 0x3C -> no partial frame stored; clean 0x3C received. 5-bit width with 0x1F -> rx_data=0x1F.
- With UART_RX_TIMEOUT_EN, TIMEOUT_CHARS=4, one frame then idle -> rx_timeout rises after 320 baud_en ticks and clears on pop.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the uart_rx_multi receiver.
//   rx_state_t  - receive FSM states
//   rx_word_t   - FIFO entry {perr, ferr, data}
//   FIFO_W      - FIFO entry width (10)
//   PARITY_*    - parity mode encodings for cfg_parity_odd
//   DEFAULT_OSR - default oversampling ratio
//   eff_width() - maps cfg_data_width to the width actually used (5..8)
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_word_t;

    localparam int   FIFO_W      = $bits(rx_word_t);
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam int   DEFAULT_OSR = 8;

    // Out-of-range widths fall back to 8 data bits.
    function automatic logic [3:0] eff_width(input logic [3:0] w);
        return (w >= 4'd5 && w <= 4'd8) ? w : 4'd8;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst      - clock, synchronous active-high reset
//   push, wdata   - write request and data (ignored when full unless popping)
//   pop           - read request (ignored when empty)
//   rdata         - head entry, valid whenever !empty, zero when empty
//   full, empty   - occupancy flags
//   level         - entry count, 0..DEPTH
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_FULL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push && (!full || do_pop);
    // Head is gated so the outputs read zero while empty and after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: oversampling UART receiver (5..8 data bits, optional parity,
// 1/2 stop bits) feeding a FWFT FIFO drained with a valid/ready handshake.
// Optional idle timeout is built when UART_RX_TIMEOUT_EN is defined; otherwise
// rx_timeout is tied low.
//   clk_uart, rst       - clock, synchronous active-high reset
//   baud_en             - oversample tick (OSR x baud)
//   cfg_*               - frame format, latched at each start edge
//   rx_in               - asynchronous serial line, idle high
//   rx_data/perr/ferr   - FIFO head entry
//   rx_valid, rx_ready  - FIFO not empty / consumer accept (pop)
//   rx_overflow,ovf_clr - sticky lost-frame flag and its clear
//   fifo_level          - FIFO entry count
//   rx_timeout          - idle timeout with data pending
module uart_rx_multi
    import uart_rx_pkg::*;
#(
    parameter int OSR           = DEFAULT_OSR,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                          clk_uart,
    input  logic                          rst,
    input  logic                          baud_en,
    input  logic [3:0]                    cfg_data_width,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    input  logic                          cfg_err_drop,
    input  logic                          rx_in,
    output logic [7:0]                    rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rx_timeout
);

    if (OSR < 4 || OSR > 16 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CHARS < 1) begin : g_param_err
        $error("uart_rx_multi: illegal parameter value");
    end

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);
    localparam logic [CW-1:0] MID     = CW'(OSR / 2);
    localparam logic [CW-1:0] MID_LO  = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] MID_HI  = CW'(OSR / 2 + 1);

    rx_state_t      state;
    logic [2:0]     sync;
    logic           s1;
    logic           s2;
    logic [CW-1:0]  cnt;
    logic [1:0]     vsamp;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           perr;
    logic           ferr;
    logic [3:0]     c_width;
    logic           c_par_en;
    logic           c_par_odd;
    logic           c_stop2;
    logic           c_drop;
    logic           push;
    rx_word_t       push_word;
    rx_word_t       head;
    logic           start_edge;
    logic           decide;
    logic           vote;
    logic           ferr_n;
    logic           full;
    logic           empty;
    logic           pop;

    assign s1         = sync[1];
    assign s2         = sync[2];
    assign start_edge = (state == ST_IDLE) && s2 && !s1;
    // The third vote sample is s1 itself on the decision tick.
    assign decide     = baud_en && (cnt == MID_HI);
    assign vote       = (vsamp[0] & vsamp[1]) | (vsamp[0] & s1) | (vsamp[1] & s1);
    assign ferr_n     = ferr | ~vote;
    assign pop        = rx_valid && rx_ready;

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            sync      <= '1;
            state     <= ST_IDLE;
            cnt       <= '0;
            vsamp     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            c_width   <= 4'd8;
            c_par_en  <= 1'b0;
            c_par_odd <= PARITY_EVEN;
            c_stop2   <= 1'b0;
            c_drop    <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
        end else begin
            sync <= {sync[1:0], rx_in};
            push <= 1'b0;

            if (state != ST_IDLE && baud_en) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                if (cnt == MID_LO) vsamp[0] <= s1;
                if (cnt == MID)    vsamp[1] <= s1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state     <= ST_START;
                        cnt       <= '0;
                        bit_idx   <= '0;
                        shreg     <= '0;
                        perr      <= 1'b0;
                        ferr      <= 1'b0;
                        c_width   <= eff_width(cfg_data_width);
                        c_par_en  <= cfg_parity_en;
                        c_par_odd <= cfg_parity_odd;
                        c_stop2   <= cfg_stop2;
                        c_drop    <= cfg_err_drop;
                    end
                end
                ST_START: begin
                    if (decide) state <= vote ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (decide) begin
                        shreg[bit_idx] <= vote;
                        bit_idx        <= bit_idx + 1'b1;
                        if ({1'b0, bit_idx} == c_width - 4'd1)
                            state <= c_par_en ? ST_PARITY : ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        // Upper bits of shreg stay 0, so the full XOR covers only data.
                        perr  <= (vote != (^shreg ^ c_par_odd));
                        state <= ST_STOP1;
                    end
                end
                ST_STOP1, ST_STOP2: begin
                    if (decide) begin
                        ferr <= ferr_n;
                        if (state == ST_STOP1 && c_stop2) begin
                            state <= ST_STOP2;
                        end else begin
                            // Word is captured here so a quick new start edge cannot
                            // disturb it before the push cycle.
                            state     <= ST_IDLE;
                            push      <= !(c_drop && (perr || ferr_n));
                            push_word <= '{perr: perr, ferr: ferr_n, data: shreg};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk_uart),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_word),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign rx_valid = !empty;
    assign rx_data  = head.data;
    assign rx_perr  = head.perr;
    assign rx_ferr  = head.ferr;

    // A set beats a clear in the same cycle.
    always_ff @(posedge clk_uart) begin
        if (rst)
            rx_overflow <= 1'b0;
        else if (push && full && !pop)
            rx_overflow <= 1'b1;
        else if (ovf_clr)
            rx_overflow <= 1'b0;
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_CHARS * 10 * OSR;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_flag;

    always_ff @(posedge clk_uart) begin
        if (rst || empty || start_edge) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (state == ST_IDLE && baud_en && !to_flag) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TW'(TO_LIMIT - 1)) to_flag <= 1'b1;
        end
    end

    assign rx_timeout = to_flag;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: randomized self-checking bench for uart_rx_multi
// (OSR=8, FIFO_DEPTH=4). Expected FIFO contents come from a queue model
// built from the frame format rules.
module tb_uart_rx_multi;

    localparam int OSR   = 8;
    localparam int DEPTH = 4;
    localparam int TCH   = 4;

    logic       clk_uart = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic [3:0] cfg_data_width = 4'd8;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       cfg_err_drop = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_valid;
    logic       rx_overflow;
    logic [2:0] fifo_level;
    logic       rx_timeout;

    int         n_chk = 0;
    int         n_pass = 0;
    int         bdiv = 0;
    logic [9:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    uart_rx_multi #(.OSR(OSR), .FIFO_DEPTH(DEPTH), .TIMEOUT_CHARS(TCH)) dut (
        .clk_uart       (clk_uart),
        .rst            (rst),
        .baud_en        (baud_en),
        .cfg_data_width (cfg_data_width),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .cfg_err_drop   (cfg_err_drop),
        .rx_in          (rx_in),
        .rx_data        (rx_data),
        .rx_perr        (rx_perr),
        .rx_ferr        (rx_ferr),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_overflow    (rx_overflow),
        .ovf_clr        (ovf_clr),
        .fifo_level     (fifo_level),
        .rx_timeout     (rx_timeout)
    );

    always #5 clk_uart = ~clk_uart;

    // One-cycle baud tick every third clock, changed away from the active edge.
    always @(negedge clk_uart) begin
        bdiv    = (bdiv == 2) ? 0 : bdiv + 1;
        baud_en = (bdiv == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Wait for n baud ticks; returns just after the last ticking edge.
    task automatic hold(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk_uart);
            if (baud_en) k++;
        end
        #1;
    endtask

    task automatic drv(input logic v, input int n);
        rx_in = v;
        hold(n);
    endtask

    task automatic clk1();
        @(posedge clk_uart);
        #1;
    endtask

    // mode 0: plain, 1: check push latency, 2: pop coincident with the push
    task automatic send_frame(input logic [7:0] val, input logic [3:0] w,
                              input logic pen, input logic podd, input logic st2,
                              input logic drop, input logic bad_par,
                              input logic bad_s1, input logic bad_s2, input int mode);
        int         we;
        int         lvl0;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        we = (w >= 5 && w <= 8) ? int'(w) : 8;
        d  = val & 8'((1 << we) - 1);
        cfg_data_width = w;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = st2;
        cfg_err_drop   = drop;
        drv(1'b1, 2);
        drv(1'b0, OSR);
        // Format is latched at the start edge; later input changes must not matter.
        cfg_data_width = 4'($urandom_range(0, 15));
        cfg_parity_en  = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2      = 1'($urandom);
        cfg_err_drop   = 1'($urandom);
        for (int i = 0; i < we; i++) drv(d[i], OSR);
        if (pen) drv((^d) ^ podd ^ bad_par, OSR);
        if (st2) drv(!bad_s1, OSR);
        rx_in = st2 ? !bad_s2 : !bad_s1;
        lvl0  = int'(fifo_level);
        hold(OSR - 1);
        if (mode == 1) begin
            chk("push_lat_pre", fifo_level, lvl0);
            clk1();
            chk("push_lat_post", fifo_level, lvl0 + 1);
            chk("push_lat_valid", rx_valid, 1);
        end else if (mode == 2) begin
            rx_ready = 1'b1;
            clk1();
            rx_ready = 1'b0;
        end
        hold(1);
        pe = pen & bad_par;
        fe = bad_s1 | (st2 & bad_s2);
        if (mode == 2 && exp_q.size() > 0) void'(exp_q.pop_front());
        if (!(drop && (pe | fe))) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({pe, fe, d});
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic drain();
        logic [9:0] e;
        chk("level", fifo_level, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", rx_valid, 1);
            chk("entry", {rx_perr, rx_ferr, rx_data}, e);
            rx_ready = 1'b1;
            clk1();
            rx_ready = 1'b0;
        end
        chk("drained", rx_valid, 0);
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        clk1();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_clr", rx_overflow, 0);
    endtask

    initial begin
        logic [3:0] w;
        int         nf;

        repeat (4) clk1();
        rst = 1'b0;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_perr", rx_perr, 0);
        chk("rst_ferr", rx_ferr, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", rx_overflow, 0);
        chk("rst_timeout", rx_timeout, 0);

        // 8N1 0xA5 with push latency check
        send_frame(8'hA5, 4'd8, 0, 0, 0, 0, 0, 0, 0, 1);
        drain();

        // 7E1 0x35 with corrupted parity, kept then dropped
        send_frame(8'h35, 4'd7, 1, 0, 0, 0, 1, 0, 0, 0);
        drain();
        send_frame(8'h35, 4'd7, 1, 0, 0, 1, 1, 0, 0, 0);
        drain();

        // 8N2 with bad second stop bit
        send_frame(8'h5A, 4'd8, 0, 0, 1, 0, 0, 0, 1, 0);
        drain();

        // Short low glitch: false start, nothing stored
        drv(1'b1, 2);
        drv(1'b0, 3);
        drv(1'b1, 2 * OSR);
        chk("glitch_level", fifo_level, 0);
        chk("glitch_valid", rx_valid, 0);

        // Overflow at depth 4
        for (int f = 0; f < 5; f++)
            send_frame(8'($urandom), 4'd8, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_level", fifo_level, DEPTH);
        chk("ovf_set", rx_overflow, exp_ovf);
        clear_ovf();
        send_frame(8'hC3, 4'd8, 0, 0, 0, 0, 0, 0, 0, 2);
        chk("full_pop_push_level", fifo_level, DEPTH);
        chk("full_pop_push_ovf", rx_overflow, 0);
        drain();

        // Reset in the middle of the data bits
        drv(1'b1, 2);
        drv(1'b0, OSR);
        drv(1'b1, OSR);
        drv(1'b0, OSR);
        rx_in = 1'b1;
        rst   = 1'b1;
        clk1();
        clk1();
        rst   = 1'b0;
        drv(1'b1, 2 * OSR);
        chk("rst_mid_level", fifo_level, 0);
        send_frame(8'h3C, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        send_frame(8'h1F, 4'd5, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        // Idle timeout
        send_frame(8'h42, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef UART_RX_TIMEOUT_EN
        hold(TCH * 10 * OSR - 2);
        chk("timeout_early", rx_timeout, 0);
        hold(1);
        chk("timeout_set", rx_timeout, 1);
        drain();
        clk1();
        chk("timeout_clr", rx_timeout, 0);
`else
        hold(TCH * 10 * OSR + 10);
        chk("timeout_off", rx_timeout, 0);
        drain();
`endif

        // Randomized frames in bursts, including overflow and error drops
        for (int it = 0; it < 20; it++) begin
            nf = $urandom_range(1, 5);
            for (int f = 0; f < nf; f++) begin
                w = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(5, 8));
                send_frame(8'($urandom), w, 1'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), $urandom_range(0, 3) == 0,
                           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, 0);
            end
            chk("rand_ovf", rx_overflow, exp_ovf);
            clear_ovf();
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
